dmem_word_arbiter: RTL and testbench

//  Shares the byte-wide 32-entry data memory between two word requesters: the processor

---
 rtl/dmem_word_arbiter_if.sv | 17 +
 rtl/dmem_word_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dmem_word_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_word_arbiter_if.sv
// Word-request channel between one requester (CPU or loader) and the
// data-memory arbiter. The requester drives the command; the arbiter
// returns a one-cycle ack with read data and the error flag.
interface dmem_word_arbiter_if #(
  parameter int ADDR_W = 5
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ack;
  logic [31:0]       rdata;
  logic              err;

  modport master (output req, we, addr, wdata, input ack, rdata, err);
  modport slave  (input req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/dmem_word_arbiter.sv
// dmem_word_arbiter: shares a byte-wide data memory between the CPU and the
// loader. Each 32-bit access is split into four big-endian byte beats
// (addr+0 carries [31:24]). Round-robin arbitration, one access in flight.
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject accesses with
// addr[1:0] != 0 (ack with err = 1, no memory traffic).
module dmem_word_arbiter #(
  parameter int ADDR_W = 5,
  parameter int BEATS  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_word_arbiter_if.slave cpu,
  dmem_word_arbiter_if.slave ld,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  localparam logic       OWN_CPU   = 1'b0;
  localparam logic       OWN_LD    = 1'b1;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  state_t            state, state_next;
  logic [1:0]        beat;
  logic              owner;
  logic              last_grant;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rbuf;
  logic [31:0]       cpu_rdata_q;
  logic [31:0]       ld_rdata_q;
  logic [31:0]       rdata_next;
  logic [1:0]        byte_sel;

  logic              grant_valid;
  logic              grant_sel;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              sel_misaligned;

  // Round-robin pick: a tie goes to whoever was not served last.
  always_comb begin
    grant_valid = cpu.req | ld.req;
    grant_sel   = OWN_CPU;
    if (cpu.req && ld.req) grant_sel = ~last_grant;
    else if (ld.req)       grant_sel = OWN_LD;
    sel_we    = (grant_sel == OWN_LD) ? ld.we    : cpu.we;
    sel_addr  = (grant_sel == OWN_LD) ? ld.addr  : cpu.addr;
    sel_wdata = (grant_sel == OWN_LD) ? ld.wdata : cpu.wdata;
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign sel_misaligned = (sel_addr[1:0] != 2'b00);
`else
  assign sel_misaligned = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode; misaligned requests (when checked) bypass the beats.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = sel_misaligned ? DONE : XFER;
      XFER:    if (beat == LAST_BEAT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Byte lane of the current beat: beat 0 is the most significant byte.
  assign byte_sel = LAST_BEAT - beat;

  // Read word with the byte arriving this beat merged in.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
    assign rdata_next[8*gi +: 8] = (byte_sel == 2'(gi)) ? mem_rdata : rbuf[8*gi +: 8];
  end

  // Command latch, beat counter, load assembly and per-requester read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat        <= 2'd0;
      owner       <= OWN_CPU;
      last_grant  <= OWN_LD;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rbuf        <= '0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner      <= grant_sel;
            last_grant <= grant_sel;
            we_q       <= sel_we;
            addr_q     <= sel_addr;
            wdata_q    <= sel_wdata;
            beat       <= 2'd0;
            rbuf       <= '0;
            // A rejected access completes next cycle with zero read data.
            if (sel_misaligned) begin
              if (grant_sel == OWN_LD) ld_rdata_q  <= '0;
              else                     cpu_rdata_q <= '0;
            end
          end
        end
        XFER: begin
          beat <= beat + 2'd1;
          if (!we_q) rbuf <= rdata_next;
          // Publish the finished word as DONE begins; stores report 0.
          if (beat == LAST_BEAT) begin
            if (owner == OWN_LD) ld_rdata_q  <= we_q ? 32'd0 : rdata_next;
            else                 cpu_rdata_q <= we_q ? 32'd0 : rdata_next;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory side is driven only during beats, so a reset clears it at once.
  assign busy      = (state != IDLE);
  assign mem_we    = (state == XFER) && we_q;
  assign mem_addr  = (state == XFER) ? addr_q + ADDR_W'(beat) : '0;
  assign mem_wdata = (state == XFER) ? wdata_q[{byte_sel, 3'b000} +: 8] : 8'd0;

  assign cpu.ack   = (state == DONE) && (owner == OWN_CPU);
  assign ld.ack    = (state == DONE) && (owner == OWN_LD);
  assign cpu.rdata = cpu_rdata_q;
  assign ld.rdata  = ld_rdata_q;

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q;

  // Remember whether the granted access was rejected for misalignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         err_q <= 1'b0;
    else if (state == IDLE && grant_valid) err_q <= sel_misaligned;
  end

  assign cpu.err = cpu.ack & err_q;
  assign ld.err  = ld.ack & err_q;
`else
  assign cpu.err = 1'b0;
  assign ld.err  = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_word_arbiter.sv
// Directed testbench for dmem_word_arbiter with a behavioural byte memory.
module tb_dmem_word_arbiter;
  logic       clk;
  logic       rst_n;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       preset;
  logic [7:0] mem [32];

  int n_checks = 0;
  int n_fail   = 0;

  dmem_word_arbiter_if #(.ADDR_W(5)) cpu_if ();
  dmem_word_arbiter_if #(.ADDR_W(5)) ld_if ();

  dmem_word_arbiter #(.ADDR_W(5), .BEATS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu       (cpu_if.slave),
    .ld        (ld_if.slave),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory: preset to mem[i] = i, then written on posedge when mem_we.
  always @(posedge clk) begin
    if (preset) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One word access; returns latency in cycles after the req-sampling edge.
  task automatic access(input bit is_ld, input bit we, input logic [4:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output int lat, output logic err, output logic other_ack,
                        output logic saw_we);
    logic ack;
    logic oth;
    @(negedge clk);
    if (is_ld) begin
      ld_if.req = 1'b1; ld_if.we = we; ld_if.addr = addr; ld_if.wdata = wdata;
    end else begin
      cpu_if.req = 1'b1; cpu_if.we = we; cpu_if.addr = addr; cpu_if.wdata = wdata;
    end
    lat = -1; rdata = '0; err = 1'b0; other_ack = 1'b0; saw_we = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_we) saw_we = 1'b1;
      ack = is_ld ? ld_if.ack : cpu_if.ack;
      oth = is_ld ? cpu_if.ack : ld_if.ack;
      if (oth) other_ack = 1'b1;
      if (ack) begin
        lat   = k;
        rdata = is_ld ? ld_if.rdata : cpu_if.rdata;
        err   = is_ld ? ld_if.err : cpu_if.err;
        break;
      end
    end
    cpu_if.req = 1'b0;
    ld_if.req  = 1'b0;
    $display("access %s we=%0d addr=%0d wdata=%h -> lat=%0d rdata=%h err=%0d",
             is_ld ? "LD " : "CPU", we, addr, wdata, lat, rdata, err);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    logic        err, oth, swe;
    int          ack_who [4];
    int          ack_at  [4];
    int          n_acks;

    rst_n  = 1'b0;
    preset = 1'b1;
    cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0;
    ld_if.req  = 1'b0; ld_if.we  = 1'b0; ld_if.addr  = '0; ld_if.wdata  = '0;

    // Test 1: reset state, then a CPU store.
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_mem_bus", {22'd0, mem_we, mem_addr, mem_wdata}, 32'd0);
    check("reset_cpu_out", {30'd0, cpu_if.ack, cpu_if.err}, 32'd0);
    check("reset_cpu_rdata", cpu_if.rdata, 32'd0);
    check("reset_ld_out", {30'd0, ld_if.ack, ld_if.err}, 32'd0);
    check("reset_ld_rdata", ld_if.rdata, 32'd0);
    preset = 1'b0;
    rst_n  = 1'b1;

    access(1'b0, 1'b1, 5'd8, 32'hDEADBEEF, rd, lat, err, oth, swe);
    check("t1_lat", 32'(lat), 32'd5);
    check("t1_mem", {mem[8], mem[9], mem[10], mem[11]}, 32'hDEADBEEF);
    check("t1_err", 32'(err), 32'd0);

    // Test 2: CPU load back; loader never acked; rdata holds afterwards.
    access(1'b0, 1'b0, 5'd8, 32'h0, rd, lat, err, oth, swe);
    check("t2_rdata", rd, 32'hDEADBEEF);
    check("t2_lat", 32'(lat), 32'd5);
    check("t2_ld_ack", 32'(oth), 32'd0);
    repeat (3) @(negedge clk);
    check("t2_hold", cpu_if.rdata, 32'hDEADBEEF);
    check("t2_ld_rdata", ld_if.rdata, 32'd0);

    // Test 3: simultaneous requests from reset, held continuously.
    do_reset();
    @(negedge clk);
    cpu_if.req = 1'b1; cpu_if.we = 1'b1; cpu_if.addr = 5'd12; cpu_if.wdata = 32'h01020304;
    ld_if.req  = 1'b1; ld_if.we  = 1'b1; ld_if.addr  = 5'd16; ld_if.wdata  = 32'hA1A2A3A4;
    n_acks = 0;
    for (int k = 0; k < 4; k++) begin ack_who[k] = -1; ack_at[k] = -1; end
    for (int k = 1; k <= 40 && n_acks < 4; k++) begin
      @(negedge clk);
      if (cpu_if.ack && ld_if.ack) check("t3_dual_ack", 32'd1, 32'd0);
      if (cpu_if.ack || ld_if.ack) begin
        ack_who[n_acks] = ld_if.ack ? 1 : 0;
        ack_at[n_acks]  = k;
        $display("contention ack %0d: %s at cycle %0d", n_acks, ld_if.ack ? "LD" : "CPU", k);
        n_acks++;
      end
    end
    cpu_if.req = 1'b0;
    ld_if.req  = 1'b0;
    check("t3_grant0", 32'(ack_who[0]), 32'd0);
    check("t3_grant1", 32'(ack_who[1]), 32'd1);
    check("t3_grant2", 32'(ack_who[2]), 32'd0);
    check("t3_grant3", 32'(ack_who[3]), 32'd1);
    check("t3_at0", 32'(ack_at[0]), 32'd5);
    check("t3_at1", 32'(ack_at[1]), 32'd11);
    check("t3_at3", 32'(ack_at[3]), 32'd23);
    check("t3_mem_cpu", {mem[12], mem[13], mem[14], mem[15]}, 32'h01020304);
    check("t3_mem_ld", {mem[16], mem[17], mem[18], mem[19]}, 32'hA1A2A3A4);
    @(negedge clk);
    check("t3_idle", 32'(busy), 32'd0);

    // Test 4: loader store at the top, then a wrapping load.
    access(1'b1, 1'b1, 5'd28, 32'h11223344, rd, lat, err, oth, swe);
    check("t4_mem", {mem[28], mem[29], mem[30], mem[31]}, 32'h11223344);
    check("t4_cpu_ack", 32'(oth), 32'd0);
    access(1'b1, 1'b0, 5'd30, 32'h0, rd, lat, err, oth, swe);
`ifdef DMEM_ALIGN_CHECK_EN
    check("t4_wrap_err", 32'(err), 32'd1);
    check("t4_wrap_rdata", rd, 32'd0);
    check("t4_wrap_we", 32'(swe), 32'd0);
`else
    check("t4_wrap_rdata", rd, 32'h33440001);
    check("t4_wrap_err", 32'(err), 32'd0);
    check("t4_wrap_lat", 32'(lat), 32'd5);
`endif

    // Test 5: reset during beat 2 of a store to addr 4.
    @(negedge clk);
    cpu_if.req = 1'b1; cpu_if.we = 1'b1; cpu_if.addr = 5'd4; cpu_if.wdata = 32'hAABBCCDD;
    repeat (3) @(negedge clk);
    check("t5_beat2_addr", 32'(mem_addr), 32'd6);
    check("t5_beat2_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    cpu_if.req = 1'b0;
    #1;
    check("t5_rst_we", 32'(mem_we), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    oth = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (cpu_if.ack || ld_if.ack) oth = 1'b1;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (cpu_if.ack || ld_if.ack) oth = 1'b1;
    end
    check("t5_no_ack", 32'(oth), 32'd0);
    check("t5_mem", {mem[4], mem[5], mem[6], mem[7]}, 32'hAABB0607);
    check("t5_idle", 32'(busy), 32'd0);
    $display("reset mid-store: bytes 4..7 = %h %h %h %h", mem[4], mem[5], mem[6], mem[7]);

`ifdef DMEM_ALIGN_CHECK_EN
    // Test 6: misaligned CPU store is rejected without touching memory.
    access(1'b0, 1'b1, 5'd5, 32'h55667788, rd, lat, err, oth, swe);
    check("t6_err", 32'(err), 32'd1);
    check("t6_lat", 32'(lat >= 1 && lat <= 2), 32'd1);
    check("t6_no_we", 32'(swe), 32'd0);
    check("t6_mem", {mem[4], mem[5], mem[6], mem[7]}, 32'hAABB0607);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
